twiddle_cmult_pipe: RTL and testbench

- Parametrised, multi-lane complex twiddle multiplier for the 2-D FFT datapath, placed between butterfly stages.
- Each lane computes X·W in fixed point, with per-lane bypass, runtime round/saturate control, an overflow flag and a valid/ready handshake with full-pipeline stall.
- Generalises the fixed 4-point, 2-cycle twiddle stage to any lane count and width, and adds flow control the fixed stage lacks.

---
 rtl/twiddle_cmult_pipe.sv | 188 ++++++++++++++++++
 tb/tb_twiddle_cmult_pipe.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_cmult_pipe.sv
// -----------------------------------------------------------------------------
// twiddle_cmult_pipe
//
// Multi-lane complex twiddle multiplier for the 2-D FFT datapath. It sits
// between butterfly stages. Each lane computes X*W in fixed point through
// three pipeline stages:
//   S1  products ar*br, ai*bi, ar*bi, ai*br        (DW+WW bits)
//   S2  re = p1 - p2, im = p3 + p4                  (DW+WW+1 bits)
//   S3  optional round-half-up, >>> FRAC, range check, then saturate or wrap
// Lanes selected by BYPASS_MASK carry their input through the same three
// stages unchanged. No multiplier is built for those lanes.
// round_en/sat_en are captured with each beat and travel alongside it.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   in_valid / in_ready   input handshake (in_ready = out_ready | ~out_valid)
//   in_re, in_im          LANES x DW packed operands, lane k at [k*DW +: DW]
//   w_re, w_im            LANES x WW packed twiddles
//   round_en, sat_en      per-beat rounding / saturation mode
//   out_valid / out_ready output handshake
//   out_re, out_im        LANES x DW packed results
//   out_ovf               per-lane out-of-range flag (set in sat and wrap mode)
// -----------------------------------------------------------------------------
module twiddle_cmult_pipe #(
  parameter int unsigned      LANES       = 4,
  parameter int unsigned      DW          = 16,
  parameter int unsigned      WW          = 16,
  parameter int unsigned      FRAC        = 8,
  parameter logic [LANES-1:0] BYPASS_MASK = LANES'(1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*DW-1:0]   in_re,
  input  logic [LANES*DW-1:0]   in_im,
  input  logic [LANES*WW-1:0]   w_re,
  input  logic [LANES*WW-1:0]   w_im,
  input  logic                  round_en,
  input  logic                  sat_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*DW-1:0]   out_re,
  output logic [LANES*DW-1:0]   out_im,
  output logic [LANES-1:0]      out_ovf
);

  localparam int unsigned PW = DW + WW;
  localparam int unsigned SW = PW + 1;
  // One extra guard bit so adding the rounding offset can never wrap.
  localparam int unsigned RW = PW + 2;

  localparam logic signed [RW-1:0] RND_OFS  = RW'((64'd1 << FRAC) >> 1);
  localparam logic signed [RW-1:0] RND_ZERO = '0;

  // {ovf, value}: the value is in range when every bit from the MSB down to
  // bit DW-1 holds the same sign.
  function automatic logic [DW:0] fit(input logic signed [RW-1:0] v,
                                      input logic               sat);
    logic [RW-DW:0] top;
    logic           ovf;
    logic [DW-1:0]  val;
    top = v[RW-1:DW-1];
    ovf = ~((&top) | ~(|top));
    if (ovf && sat) begin
      val = v[RW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end else begin
      val = v[DW-1:0];
    end
    return {ovf, val};
  endfunction

  // ---------------------------------------------------------------------------
  // Pipeline control: every stage advances together, and bubbles are kept.
  // ---------------------------------------------------------------------------
  logic v1_q, v2_q, v3_q;
  logic rnd1_q, sat1_q, rnd2_q, sat2_q;
  logic adv;

  assign adv       = out_ready | ~v3_q;
  assign in_ready  = adv;
  assign out_valid = v3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      rnd1_q <= 1'b0;
      sat1_q <= 1'b0;
      rnd2_q <= 1'b0;
      sat2_q <= 1'b0;
    end else if (adv) begin
      v1_q   <= in_valid;
      v2_q   <= v1_q;
      v3_q   <= v2_q;
      rnd1_q <= round_en;
      sat1_q <= sat_en;
      rnd2_q <= rnd1_q;
      sat2_q <= sat1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-lane datapath
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic signed [DW-1:0] a_re, a_im;
    logic signed [PW-1:0] p1_d, p2_d, p3_d, p4_d;
    logic signed [PW-1:0] p1_q, p2_q, p3_q, p4_q;
    logic signed [SW-1:0] s_re_d, s_im_d, s_re_q, s_im_q;
    logic [DW-1:0]        o_re_d, o_im_d, o_re_q, o_im_q;
    logic                 ovf_d, ovf_q;

    assign a_re = in_re[k*DW +: DW];
    assign a_im = in_im[k*DW +: DW];

    if (BYPASS_MASK[k]) begin : g_byp
      // Bypass data rides in p1/p3 so that S2 passes it through unchanged.
      logic bypass_unused;
      assign bypass_unused = ^{w_re[k*WW +: WW], w_im[k*WW +: WW],
                               s_re_q[SW-1:DW], s_im_q[SW-1:DW]};
      assign p1_d   = PW'(a_re);
      assign p2_d   = '0;
      assign p3_d   = PW'(a_im);
      assign p4_d   = '0;
      assign o_re_d = s_re_q[DW-1:0];
      assign o_im_d = s_im_q[DW-1:0];
      assign ovf_d  = 1'b0;
    end else begin : g_mul
      logic signed [WW-1:0] b_re, b_im;
      logic signed [RW-1:0] ofs, sum_re, sum_im, sh_re, sh_im;
      logic [DW:0]          f_re, f_im;

      assign b_re = w_re[k*WW +: WW];
      assign b_im = w_im[k*WW +: WW];
      assign p1_d = PW'(a_re) * PW'(b_re);
      assign p2_d = PW'(a_im) * PW'(b_im);
      assign p3_d = PW'(a_re) * PW'(b_im);
      assign p4_d = PW'(a_im) * PW'(b_re);

      always_comb begin
        ofs    = rnd2_q ? RND_OFS : RND_ZERO;
        sum_re = RW'(s_re_q) + ofs;
        sum_im = RW'(s_im_q) + ofs;
        sh_re  = sum_re >>> FRAC;
        sh_im  = sum_im >>> FRAC;
        f_re   = fit(sh_re, sat2_q);
        f_im   = fit(sh_im, sat2_q);
        o_re_d = f_re[DW-1:0];
        o_im_d = f_im[DW-1:0];
        ovf_d  = f_re[DW] | f_im[DW];
      end
    end

    assign s_re_d = SW'(p1_q) - SW'(p2_q);
    assign s_im_d = SW'(p3_q) + SW'(p4_q);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        p1_q   <= '0;
        p2_q   <= '0;
        p3_q   <= '0;
        p4_q   <= '0;
        s_re_q <= '0;
        s_im_q <= '0;
        o_re_q <= '0;
        o_im_q <= '0;
        ovf_q  <= 1'b0;
      end else if (adv) begin
        p1_q   <= p1_d;
        p2_q   <= p2_d;
        p3_q   <= p3_d;
        p4_q   <= p4_d;
        s_re_q <= s_re_d;
        s_im_q <= s_im_d;
        o_re_q <= o_re_d;
        o_im_q <= o_im_d;
        ovf_q  <= ovf_d;
      end
    end

    assign out_re[k*DW +: DW] = o_re_q;
    assign out_im[k*DW +: DW] = o_im_q;
    assign out_ovf[k]         = ovf_q;
  end

endmodule

// File: tb/tb_twiddle_cmult_pipe.sv
module tb_twiddle_cmult_pipe;
  localparam int LANES = 4;
  localparam int DW    = 16;
  localparam int WW    = 16;
  localparam int FRAC  = 8;
  localparam int VW    = LANES * DW;
  localparam logic [LANES-1:0] BYP = 4'b0001;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [VW-1:0]       in_re = '0, in_im = '0;
  logic [LANES*WW-1:0] w_re = '0, w_im = '0;
  logic                round_en = 1'b0, sat_en = 1'b0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [VW-1:0]       out_re, out_im;
  logic [LANES-1:0]    out_ovf;

  twiddle_cmult_pipe #(
    .LANES(LANES), .DW(DW), .WW(WW), .FRAC(FRAC), .BYPASS_MASK(BYP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .w_re(w_re), .w_im(w_im),
    .round_en(round_en), .sat_en(sat_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VW-1:0]    re;
    logic [VW-1:0]    im;
    logic [LANES-1:0] ovf;
  } beat_t;

  beat_t         exp_q[$];
  logic [DW-1:0] seq_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] s16(input int v);
    return DW'(v);
  endfunction

  function automatic logic [DW-1:0] lane(input logic [VW-1:0] v, input int k);
    return v[k*DW +: DW];
  endfunction

  // Mathematical floor of x/d for d > 0.
  function automatic longint floor_div(input longint x, input longint d);
    longint q;
    q = x / d;
    if ((x % d != 0) && (x < 0)) q = q - 1;
    return q;
  endfunction

  // {ovf, value}: clamp to the signed DW range, or keep the low DW bits.
  function automatic logic [DW:0] fit(input longint v, input logic sat);
    longint hi, lo;
    hi = (longint'(1) <<< (DW - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return {1'b1, sat ? DW'(hi) : DW'(v)};
    if (v < lo) return {1'b1, sat ? DW'(lo) : DW'(v)};
    return {1'b0, DW'(v)};
  endfunction

  function automatic beat_t model(input logic [VW-1:0] are, input logic [VW-1:0] aim,
                                 input logic [LANES*WW-1:0] bre, input logic [LANES*WW-1:0] bim,
                                 input logic rnd, input logic sat);
    beat_t b;
    logic [DW:0] fr, fi;
    longint ar, ai, wr, wi, xr, xi;
    for (int k = 0; k < LANES; k++) begin
      if (BYP[k]) begin
        b.re[k*DW +: DW] = are[k*DW +: DW];
        b.im[k*DW +: DW] = aim[k*DW +: DW];
        b.ovf[k]         = 1'b0;
      end else begin
        ar = longint'($signed(are[k*DW +: DW]));
        ai = longint'($signed(aim[k*DW +: DW]));
        wr = longint'($signed(bre[k*WW +: WW]));
        wi = longint'($signed(bim[k*WW +: WW]));
        xr = ar * wr - ai * wi;
        xi = ar * wi + ai * wr;
        if (rnd) begin
          xr = xr + (longint'(1) <<< (FRAC - 1));
          xi = xi + (longint'(1) <<< (FRAC - 1));
        end
        fr = fit(floor_div(xr, longint'(1) <<< FRAC), sat);
        fi = fit(floor_div(xi, longint'(1) <<< FRAC), sat);
        b.re[k*DW +: DW] = fr[DW-1:0];
        b.im[k*DW +: DW] = fi[DW-1:0];
        b.ovf[k]         = fr[DW] | fi[DW];
      end
    end
    return b;
  endfunction

  // Scoreboard and stall monitor, sampled mid-cycle.
  logic             st_prev = 1'b0;
  logic [VW-1:0]    h_re, h_im;
  logic [LANES-1:0] h_ovf;
  beat_t            e;

  always @(negedge clk) begin
    if (!rst_n) begin
      st_prev = 1'b0;
    end else begin
      if (st_prev) begin
        chk("stall_hold_valid", 64'(out_valid), 64'd1);
        chk("stall_hold_re",    64'(out_re),    64'(h_re));
        chk("stall_hold_im",    64'(out_im),    64'(h_im));
        chk("stall_hold_ovf",   64'(out_ovf),   64'(h_ovf));
      end
      if (out_valid && !out_ready) chk("stall_in_ready", 64'(in_ready), 64'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_re",  64'(out_re),  64'(e.re));
          chk("sb_im",  64'(out_im),  64'(e.im));
          chk("sb_ovf", 64'(out_ovf), 64'(e.ovf));
          seq_q.push_back(lane(out_re, 1));
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(in_re, in_im, w_re, w_im, round_en, sat_en));
      st_prev = out_valid && !out_ready;
      h_re    = out_re;
      h_im    = out_im;
      h_ovf   = out_ovf;
    end
  end

  // One beat into an empty pipe; the result must show up after the third edge.
  task automatic send_one(input logic [VW-1:0] are, input logic [VW-1:0] aim,
                          input logic [LANES*WW-1:0] bre, input logic [LANES*WW-1:0] bim,
                          input logic rnd, input logic sat);
    in_re = are; in_im = aim; w_re = bre; w_im = bim;
    round_en = rnd; sat_en = sat; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lat_edge1_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat_edge2_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat_edge3_valid", 64'(out_valid), 64'd1);
  endtask

  logic [VW-1:0]       vr, vi;
  logic [LANES*WW-1:0] br, bi;
  int                  cyc, nb;
  logic                acc;

  initial begin
    #2 rst_n = 1'b0;
    #10;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_re",    64'(out_re),    64'd0);
    chk("rst_out_im",    64'(out_im),    64'd0);
    chk("rst_out_ovf",   64'(out_ovf),   64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Identity on lane 1, bypass on lane 0
    vr = '0; vi = '0; br = '0; bi = '0;
    vr[DW +: DW] = s16(1234); vi[DW +: DW] = s16(-567); br[WW +: WW] = s16(256);
    vr[0 +: DW]  = s16(7);    vi[0 +: DW]  = s16(9);
    send_one(vr, vi, br, bi, 1'b0, 1'b0);
    chk("ident_re1", 64'(lane(out_re, 1)), 64'(s16(1234)));
    chk("ident_im1", 64'(lane(out_im, 1)), 64'(s16(-567)));
    chk("byp_re0",   64'(lane(out_re, 0)), 64'(s16(7)));
    chk("byp_im0",   64'(lane(out_im, 0)), 64'(s16(9)));
    chk("ident_ovf", 64'(out_ovf), 64'd0);

    // Rotation by j on lane 2
    vr = '0; vi = '0; br = '0; bi = '0;
    vr[2*DW +: DW] = s16(100); vi[2*DW +: DW] = s16(50); bi[2*WW +: WW] = s16(256);
    send_one(vr, vi, br, bi, 1'b0, 1'b0);
    chk("rotj_re2", 64'(lane(out_re, 2)), 64'(s16(-50)));
    chk("rotj_im2", 64'(lane(out_im, 2)), 64'(s16(100)));

    // Rotation by -pi/4
    vr = '0; vi = '0; br = '0; bi = '0;
    vr[2*DW +: DW] = s16(256); br[2*WW +: WW] = s16(181); bi[2*WW +: WW] = s16(-181);
    send_one(vr, vi, br, bi, 1'b0, 1'b0);
    chk("rot45_re2", 64'(lane(out_re, 2)), 64'(s16(181)));
    chk("rot45_im2", 64'(lane(out_im, 2)), 64'(s16(-181)));

    // Rounding: 1.5 and -1.5
    vr = '0; vi = '0; br = '0; bi = '0;
    vr[DW +: DW] = s16(3); br[WW +: WW] = s16(128);
    send_one(vr, vi, br, bi, 1'b0, 1'b0);
    chk("trunc_pos", 64'(lane(out_re, 1)), 64'(s16(1)));
    send_one(vr, vi, br, bi, 1'b1, 1'b0);
    chk("round_pos", 64'(lane(out_re, 1)), 64'(s16(2)));
    vr[DW +: DW] = s16(-3);
    send_one(vr, vi, br, bi, 1'b0, 1'b0);
    chk("trunc_neg", 64'(lane(out_re, 1)), 64'(s16(-2)));
    send_one(vr, vi, br, bi, 1'b1, 1'b0);
    chk("round_neg", 64'(lane(out_re, 1)), 64'(s16(-1)));

    // Overflow on lane 3, saturate then wrap
    vr = '0; vi = '0; br = '0; bi = '0;
    vr[3*DW +: DW] = s16(32767); vi[3*DW +: DW] = s16(32767);
    br[3*WW +: WW] = s16(256);   bi[3*WW +: WW] = s16(-256);
    send_one(vr, vi, br, bi, 1'b0, 1'b1);
    chk("sat_re3",  64'(lane(out_re, 3)), 64'(s16(32767)));
    chk("sat_im3",  64'(lane(out_im, 3)), 64'(s16(0)));
    chk("sat_ovf",  64'(out_ovf), 64'(4'b1000));
    send_one(vr, vi, br, bi, 1'b0, 1'b0);
    chk("wrap_re3", 64'(lane(out_re, 3)), 64'(s16(-2)));
    chk("wrap_im3", 64'(lane(out_im, 3)), 64'(s16(0)));
    chk("wrap_ovf", 64'(out_ovf), 64'(4'b1000));
    @(posedge clk); #1;

    // Backpressure: 8 beats, downstream stalled for cycles 4..9, modes toggling
    seq_q.delete();
    cyc = 0; nb = 0;
    while (nb < 8 && cyc < 60) begin
      in_re = {$urandom, $urandom}; in_im = {$urandom, $urandom};
      w_re  = {$urandom, $urandom}; w_im  = {$urandom, $urandom};
      in_re[DW +: DW] = s16(nb + 1);
      w_re[WW +: WW]  = s16(256);
      w_im[WW +: WW]  = '0;
      round_en = nb[0]; sat_en = nb[1];
      in_valid = 1'b1;
      out_ready = !(cyc >= 4 && cyc <= 9);
      #1 acc = in_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) nb++;
    end
    chk("bp_accepted", 64'(nb), 64'd8);
    in_valid = 1'b0; out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("bp_count", 64'(seq_q.size()), 64'd8);
    for (int j = 0; j < 8 && j < seq_q.size(); j++)
      chk("bp_order", 64'(seq_q[j]), 64'(s16(j + 1)));

    // Random traffic with random stalls and bubbles
    for (int c = 0; c < 120; c++) begin
      in_re = {$urandom, $urandom}; in_im = {$urandom, $urandom};
      for (int k = 0; k < LANES; k++) begin
        if ($urandom_range(0, 1) == 1) begin
          w_re[k*WW +: WW] = s16(int'($urandom_range(0, 512)) - 256);
          w_im[k*WW +: WW] = s16(int'($urandom_range(0, 512)) - 256);
        end else begin
          w_re[k*WW +: WW] = WW'($urandom);
          w_im[k*WW +: WW] = WW'($urandom);
        end
      end
      round_en  = 1'($urandom);
      sat_en    = 1'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rand_drained", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;

    // Reset with three beats in flight
    for (int j = 0; j < 3; j++) begin
      in_re = {$urandom, $urandom}; in_im = {$urandom, $urandom};
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_ready", 64'(in_ready),  64'd1);
    chk("mid_rst_re",    64'(out_re),    64'd0);
    chk("mid_rst_im",    64'(out_im),    64'd0);
    chk("mid_rst_ovf",   64'(out_ovf),   64'd0);
    exp_q.delete();
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    vr = '0; vi = '0; br = '0; bi = '0;
    vr[DW +: DW] = s16(42); vi[DW +: DW] = s16(-42); br[WW +: WW] = s16(256);
    send_one(vr, vi, br, bi, 1'b0, 1'b0);
    chk("post_rst_re1", 64'(lane(out_re, 1)), 64'(s16(42)));
    chk("post_rst_im1", 64'(lane(out_im, 1)), 64'(s16(-42)));
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("final_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
